prefetch_stream_buffer: RTL and testbench

Parametrised successor of the convolution input-buffer path. It fetches an arbitrary byte range from memory through a read master in burst-sized transfers, and it may start at any beat-aligned address. Leading beats from the burst-aligned fetch are discarded, and beats are staged in an internal FIFO. The block presents a valid/ready stream with a last flag to the compute array. Requests are space-reserved, so the FIFO never overflows, and an abort flushes cleanly even while a burst is outstanding.

---
 rtl/prefetch_pkg.sv | 20 ++
 rtl/sync_fifo_fwft.sv | 87 ++++++++
 rtl/prefetch_stream_buffer.sv | 222 ++++++++++++++++++++++
 tb/tb_prefetch_stream_buffer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prefetch_pkg.sv
// Shared types and constant helpers for the prefetch stream buffer.
package prefetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARB   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FLUSH = 3'd4
    } pf_state_e;

    function automatic int beat_bytes_log2(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    function automatic int burst_bytes_log2(input int data_width, input int burst_beats);
        return $clog2((data_width / 8) * burst_beats);
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous FIFO with a registered first-word-fall-through head.
// An empty FIFO loads a pushed word straight into the head register.
module sync_fifo_fwft #(
    parameter int DATA_WIDTH = 512,
    parameter int FIFO_AW    = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_data_o,
    output logic                  head_valid_o,
    output logic [FIFO_AW:0]      count_o
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW-1:0] PTR_ONE  = {{(FIFO_AW-1){1'b0}}, 1'b1};
    localparam logic [FIFO_AW:0]   CNT_ONE  = {{FIFO_AW{1'b0}}, 1'b1};
    localparam logic [FIFO_AW:0]   CNT_ZERO = {(FIFO_AW+1){1'b0}};

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [FIFO_AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]      mem_cnt_q, count_q;
    logic [DATA_WIDTH-1:0] head_q;
    logic                  head_valid_q;
    logic                  head_free_s, mem_rd_s, mem_wr_s, bypass_s;

    assign head_free_s = !head_valid_q || pop_i;
    assign mem_rd_s    = head_free_s && (mem_cnt_q != CNT_ZERO);
    assign bypass_s    = head_free_s && (mem_cnt_q == CNT_ZERO) && push_i;
    assign mem_wr_s    = push_i && !bypass_s;

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (mem_wr_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointers, occupancy and head register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= {FIFO_AW{1'b0}};
            rd_ptr_q     <= {FIFO_AW{1'b0}};
            mem_cnt_q    <= CNT_ZERO;
            count_q      <= CNT_ZERO;
            head_q       <= {DATA_WIDTH{1'b0}};
            head_valid_q <= 1'b0;
        end else if (clear_i) begin
            wr_ptr_q     <= {FIFO_AW{1'b0}};
            rd_ptr_q     <= {FIFO_AW{1'b0}};
            mem_cnt_q    <= CNT_ZERO;
            count_q      <= CNT_ZERO;
            head_q       <= {DATA_WIDTH{1'b0}};
            head_valid_q <= 1'b0;
        end else begin
            if (mem_wr_s) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (mem_rd_s) rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({mem_wr_s, mem_rd_s})
                2'b10:   mem_cnt_q <= mem_cnt_q + CNT_ONE;
                2'b01:   mem_cnt_q <= mem_cnt_q - CNT_ONE;
                default: mem_cnt_q <= mem_cnt_q;
            endcase
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
            if (mem_rd_s) begin
                head_q       <= mem_q[rd_ptr_q];
                head_valid_q <= 1'b1;
            end else if (bypass_s) begin
                head_q       <= push_data_i;
                head_valid_q <= 1'b1;
            end else if (head_free_s) begin
                head_valid_q <= 1'b0;
            end
        end
    end

    assign head_data_o  = head_q;
    assign head_valid_o = head_valid_q;
    assign count_o      = count_q;

endmodule

// File: rtl/prefetch_stream_buffer.sv
// Burst-fetching stream buffer: reserves FIFO space per burst, drops the
// leading beats of a burst-aligned fetch and streams the range with a last flag.
module prefetch_stream_buffer
    import prefetch_pkg::*;
#(
    parameter int DATA_WIDTH  = 512,
    parameter int BURST_BEATS = 64,
    parameter int FIFO_AW     = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [63:0]           base_addr,
    input  logic [31:0]           byte_len,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_req,
    output logic [63:0]           rd_addr,
    output logic [31:0]           rd_size,
    input  logic                  rd_done,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic [FIFO_AW:0]      fill_level
);

    localparam int BEAT_LOG2  = beat_bytes_log2(DATA_WIDTH);
    localparam int BURST_LOG2 = burst_bytes_log2(DATA_WIDTH, BURST_BEATS);
    localparam logic [31:0]      BURST_BEATS_C = 32'(BURST_BEATS);
    localparam logic [63:0]      BURST_BYTES_C = 64'd1 << BURST_LOG2;
    localparam logic [FIFO_AW:0] DEPTH_C       = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0] RES_ONE       = {{FIFO_AW{1'b0}}, 1'b1};
    localparam logic [FIFO_AW:0] RES_ZERO      = {(FIFO_AW+1){1'b0}};

    pf_state_e        state_q, state_d;
    logic [31:0]      skip_q, skip_d, total_q, total_d;
    logic [31:0]      out_left_q, out_left_d, n_q, n_d;
    logic [63:0]      next_addr_q, next_addr_d, rd_addr_q, rd_addr_d;
    logic [31:0]      rd_size_q, rd_size_d;
    logic [FIFO_AW:0] reserved_q, reserved_d;
    logic             rd_req_q, rd_req_d, busy_q, busy_d, done_q, done_d;
    logic             outstanding_q, outstanding_d;

    logic [FIFO_AW:0]      fill_s, free_s;
    logic [31:0]           n_s;
    logic                  accept_s, push_s, pop_s, clear_s, abort_take_s, head_valid_s;
    logic [DATA_WIDTH-1:0] head_data_s;

    // A busy state always accepts: space for every requested beat is already reserved.
    assign accept_s     = s_tvalid && busy_q;
    assign abort_take_s = abort && ((state_q == ST_ARB) || (state_q == ST_WAIT) ||
                                    (state_q == ST_DRAIN));
    assign pop_s        = head_valid_s && m_tready && !abort_take_s;
    assign push_s       = accept_s && (state_q != ST_FLUSH) && (skip_q == 32'd0) && !abort_take_s;
    assign n_s          = (total_q < BURST_BEATS_C) ? total_q : BURST_BEATS_C;
    assign free_s       = DEPTH_C - fill_s - reserved_q;

    sync_fifo_fwft #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_AW    (FIFO_AW)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (clear_s),
        .push_i       (push_s),
        .push_data_i  (s_tdata),
        .pop_i        (pop_s),
        .head_data_o  (head_data_s),
        .head_valid_o (head_valid_s),
        .count_o      (fill_s)
    );

    // Controller next-state, reservation and skip bookkeeping.
    always_comb begin
        state_d       = state_q;
        next_addr_d   = next_addr_q;
        rd_addr_d     = rd_addr_q;
        rd_size_d     = rd_size_q;
        total_d       = total_q;
        n_d           = n_q;
        busy_d        = busy_q;
        rd_req_d      = 1'b0;
        done_d        = 1'b0;
        clear_s       = 1'b0;
        reserved_d    = accept_s ? (reserved_q - RES_ONE) : reserved_q;
        skip_d        = (accept_s && (skip_q != 32'd0)) ? (skip_q - 32'd1) : skip_q;
        out_left_d    = pop_s ? (out_left_q - 32'd1) : out_left_q;
        outstanding_d = rd_done ? 1'b0 : outstanding_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    skip_d      = 32'(base_addr[BURST_LOG2-1:0] >> BEAT_LOG2);
                    out_left_d  = byte_len >> BEAT_LOG2;
                    total_d     = 32'(base_addr[BURST_LOG2-1:0] >> BEAT_LOG2) +
                                  (byte_len >> BEAT_LOG2);
                    next_addr_d = base_addr & ~(BURST_BYTES_C - 64'd1);
                    busy_d      = 1'b1;
                    state_d     = ST_ARB;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARB: begin
                if (abort_take_s) begin
                    clear_s = 1'b1;
                    state_d = ST_FLUSH;
                end else if (32'(free_s) >= n_s) begin
                    rd_req_d      = 1'b1;
                    rd_addr_d     = next_addr_q;
                    rd_size_d     = n_s << BEAT_LOG2;
                    reserved_d    = reserved_d + n_s[FIFO_AW:0];
                    n_d           = n_s;
                    outstanding_d = 1'b1;
                    state_d       = ST_WAIT;
                end else begin
                    state_d = ST_ARB;
                end
            end
            ST_WAIT: begin
                if (abort_take_s) begin
                    clear_s = 1'b1;
                    state_d = ST_FLUSH;
                end else if (rd_done) begin
                    next_addr_d = next_addr_q + BURST_BYTES_C;
                    total_d     = total_q - n_q;
                    if (total_d != 32'd0) begin
                        state_d = ST_ARB;
                    end else if (out_left_d == 32'd0) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DRAIN: begin
                if (abort_take_s) begin
                    clear_s = 1'b1;
                    state_d = ST_FLUSH;
                end else if (out_left_d == 32'd0) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_FLUSH: begin
                // Beats of an outstanding burst are swallowed until its rd_done.
                if (!outstanding_q || rd_done) begin
                    clear_s    = 1'b1;
                    reserved_d = RES_ZERO;
                    skip_d     = 32'd0;
                    total_d    = 32'd0;
                    out_left_d = 32'd0;
                    busy_d     = 1'b0;
                    state_d    = ST_IDLE;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            skip_q        <= 32'd0;
            total_q       <= 32'd0;
            out_left_q    <= 32'd0;
            n_q           <= 32'd0;
            next_addr_q   <= 64'd0;
            rd_addr_q     <= 64'd0;
            rd_size_q     <= 32'd0;
            reserved_q    <= RES_ZERO;
            rd_req_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            outstanding_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            skip_q        <= skip_d;
            total_q       <= total_d;
            out_left_q    <= out_left_d;
            n_q           <= n_d;
            next_addr_q   <= next_addr_d;
            rd_addr_q     <= rd_addr_d;
            rd_size_q     <= rd_size_d;
            reserved_q    <= reserved_d;
            rd_req_q      <= rd_req_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            outstanding_q <= outstanding_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign rd_req     = rd_req_q;
    assign rd_addr    = rd_addr_q;
    assign rd_size    = rd_size_q;
    assign s_tready   = busy_q;
    assign m_tdata    = head_data_s;
    assign m_tvalid   = head_valid_s;
    assign m_tlast    = head_valid_s && (out_left_q == 32'd1);
    assign fill_level = fill_s;

endmodule

// File: tb/tb_prefetch_stream_buffer.sv
// Scoreboard bench for prefetch_stream_buffer: a memory responder serves bursts
// whose beat data equals its byte address, expected beats and bursts are queued at start.
module tb_prefetch_stream_buffer;

    logic         clk;
    logic         rst_n, start, abort, rd_done, s_tvalid, m_tready;
    logic [63:0]  base_addr, rd_addr;
    logic [31:0]  byte_len, rd_size;
    logic [511:0] s_tdata, m_tdata;
    logic         busy, done, rd_req, s_tready, m_tvalid, m_tlast;
    logic [7:0]   fill_level;

    int n_cmp = 0, n_err = 0;
    int beats_acc = 0, done_cnt = 0, cyc = 0, last_pop_cyc = -10, max_fill = 0;
    int rdy_pct = 100;
    bit gap_en = 1'b0;

    logic [512:0] exp_q[$];
    logic [95:0]  burst_q[$];

    prefetch_stream_buffer #(.DATA_WIDTH(512), .BURST_BEATS(64), .FIFO_AW(7)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .byte_len(byte_len),
        .abort(abort), .busy(busy), .done(done), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_size(rd_size), .rd_done(rd_done), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
        .s_tready(s_tready), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tlast(m_tlast), .fill_level(fill_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory read responder.
    initial begin
        logic [63:0] a;
        int nb, i;
        s_tvalid = 1'b0; s_tdata = 512'd0; rd_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && rd_req) begin
                a = rd_addr; nb = int'(rd_size >> 6); i = 0;
                while (i < nb) begin
                    @(posedge clk); #1;
                    s_tdata  = {8{a + 64'(i) * 64'd64}};
                    s_tvalid = gap_en ? ($urandom_range(0, 3) != 0) : 1'b1;
                    @(negedge clk);
                    if (!s_tready) break;
                    if (s_tvalid) begin i++; beats_acc++; end
                end
                @(posedge clk); #1;
                s_tvalid = 1'b0;
                if (i == nb) begin
                    rd_done = 1'b1;
                    @(posedge clk); #1;
                    rd_done = 1'b0;
                end
            end
        end
    end

    // Consumer ready.
    initial begin
        m_tready = 1'b0;
        forever begin
            @(posedge clk); #1;
            m_tready = (int'($urandom_range(0, 99)) < rdy_pct);
        end
    end

    // Output monitor and scoreboard compare.
    initial begin
        logic         prev_stall;
        logic [511:0] prev_data;
        logic [95:0]  eb;
        logic [512:0] ev;
        prev_stall = 1'b0; prev_data = 512'd0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (int'(fill_level) > max_fill) max_fill = int'(fill_level);
                if (rd_req) begin
                    if (burst_q.size() == 0) check_val("rd_req_unexpected", 1, 0);
                    else begin
                        eb = burst_q.pop_front();
                        check_val("rd_addr", rd_addr, eb[95:32]);
                        check_val("rd_size", rd_size, eb[31:0]);
                    end
                end
                if (prev_stall) begin
                    check_val("stall_valid", m_tvalid, 1);
                    check_val("stall_data", m_tdata, prev_data);
                end
                if (m_tvalid && m_tready) begin
                    if (exp_q.size() == 0) check_val("beat_unexpected", 1, 0);
                    else begin
                        ev = exp_q.pop_front();
                        check_val("beat_data", m_tdata, ev[511:0]);
                        check_val("beat_last", m_tlast, ev[512]);
                        if (ev[512]) last_pop_cyc = cyc;
                    end
                end
                if (done) begin
                    done_cnt++;
                    check_val("done_after_last_pop", cyc - last_pop_cyc, 1);
                end
                prev_stall = abort ? 1'b0 : (m_tvalid && !m_tready);
                prev_data  = m_tdata;
            end
        end
    end

    task automatic start_op(input logic [63:0] base, input int len);
        logic [63:0] nxt;
        int rem, n, skp;
        skp = int'(base[11:0] >> 6);
        rem = skp + len / 64;
        nxt = base & ~64'hFFF;
        while (rem > 0) begin
            n = (rem > 64) ? 64 : rem;
            burst_q.push_back({nxt, 32'(n * 64)});
            nxt += 64'h1000;
            rem -= n;
        end
        for (int i = 0; i < len / 64; i++)
            exp_q.push_back({(i == len / 64 - 1), {8{base + 64'(i) * 64'd64}}});
        @(posedge clk); #1;
        start = 1'b1; base_addr = base; byte_len = 32'(len);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_op(input logic [63:0] base, input int len);
        int d0;
        bit seen;
        d0 = done_cnt;
        start_op(base, len);
        seen = 1'b0;
        for (int k = 0; k < 20000 && !seen; k++) begin
            @(negedge clk);
            if (done_cnt != d0) seen = 1'b1;
        end
        check_val("done_seen", seen, 1);
        repeat (3) @(negedge clk);
        check_val("done_once", done_cnt - d0, 1);
        check_val("busy_after_done", busy, 0);
        check_val("beats_left", exp_q.size(), 0);
        check_val("bursts_left", burst_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_done"}, done, 0);
        check_val({tag, "_rd_req"}, rd_req, 0);
        check_val({tag, "_rd_addr"}, rd_addr, 0);
        check_val({tag, "_rd_size"}, rd_size, 0);
        check_val({tag, "_s_tready"}, s_tready, 0);
        check_val({tag, "_m_tvalid"}, m_tvalid, 0);
        check_val({tag, "_m_tlast"}, m_tlast, 0);
        check_val({tag, "_fill"}, fill_level, 0);
    endtask

    initial begin
        int b0, d0;
        bit ok;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; base_addr = 64'd0; byte_len = 32'd0;
        repeat (3) @(posedge clk); #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(posedge clk); #1;
        check_val("idle_abort_busy", busy, 0);

        run_op(64'h1000, 8192);
        run_op(64'h1080, 4096);
        run_op(64'h4000, 192);

        rdy_pct = 30; gap_en = 1'b1;
        run_op(64'h10000, 16384);
        rdy_pct = 100; gap_en = 1'b0;

        // Abort while a burst is partly delivered and the consumer is stalled.
        rdy_pct = 0;
        b0 = beats_acc; d0 = done_cnt;
        start_op(64'h20000, 8192);
        ok = 1'b0;
        for (int k = 0; k < 2000 && !ok; k++) begin
            @(negedge clk);
            if (beats_acc >= b0 + 20) ok = 1'b1;
        end
        check_val("abort_reach20", ok, 1);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        exp_q.delete(); burst_q.delete();
        ok = 1'b0;
        for (int k = 0; k < 500 && !ok; k++) begin
            @(negedge clk);
            if (!busy) ok = 1'b1;
        end
        check_val("abort_idle", ok, 1);
        check_val("abort_fill", fill_level, 0);
        check_val("abort_m_tvalid", m_tvalid, 0);
        check_val("abort_beats_drained", beats_acc - b0, 64);
        repeat (5) @(negedge clk);
        check_val("abort_no_done", done_cnt - d0, 0);
        rdy_pct = 100;
        run_op(64'h5000, 256);

        // Asynchronous reset in the middle of a burst.
        b0 = beats_acc;
        start_op(64'h30000, 8192);
        ok = 1'b0;
        for (int k = 0; k < 2000 && !ok; k++) begin
            @(negedge clk);
            if (beats_acc >= b0 + 10) ok = 1'b1;
        end
        check_val("rst_reach10", ok, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_q.delete(); burst_q.delete();
        #1;
        check_reset_outputs("midrst");
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b1;
        run_op(64'h7000, 1024);

        check_val("fill_max_within_depth", (max_fill <= 128), 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
